// File: rtl/game_pkg.sv
// Shared encodings and defaults for the game round controller and its tick divider.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_COUNTDOWN = 2'b01,
        ST_PLAY      = 2'b10,
        ST_GAME_OVER = 2'b11
    } game_state_e;

    localparam int DEFAULT_SAMPLE_DIV = 2000000;

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running divider producing a registered one-cycle tick every DIV cycles.
// tick is high exactly while the count sits at DIV-1; clear or !enable park it at zero.
module sample_tick_gen
    import game_pkg::*;
#(
    parameter int DIV = DEFAULT_SAMPLE_DIV
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST     = CW'(DIV - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(DIV - 2);

    logic [CW-1:0] count;

    // tick is precomputed one cycle early so it stays a flop output aligned with count==LAST
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (clear || !enable) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            tick  <= (count == PRE_LAST);
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/game_round_controller.sv
// Timed scoring round sequencer: idle -> countdown -> play -> game over,
// with saturating round score and a session high score.
module game_round_controller
    import game_pkg::*;
#(
    parameter int SAMPLE_DIV      = DEFAULT_SAMPLE_DIV,
    parameter int COUNTDOWN_TICKS = 3,
    parameter int ROUND_TICKS     = 30,
    parameter int SCORE_W         = 8,
    parameter int TIME_W          = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               in,
    output logic               sample_en,
    output logic [1:0]         state,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic [TIME_W-1:0]  time_left,
    output logic               new_high
);

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [TIME_W-1:0]  CD_LOAD   = TIME_W'(COUNTDOWN_TICKS);
    localparam logic [TIME_W-1:0]  RT_LOAD   = TIME_W'(ROUND_TICKS);
    localparam logic [TIME_W-1:0]  ONE       = TIME_W'(1);

    game_state_e        st;
    logic [SCORE_W-1:0] score_inc;
    logic               last_tick;
    logic               state_change;

    assign state = st;

    always_comb begin
        score_inc    = (score == SCORE_MAX) ? score : score + SCORE_W'(in);
        last_tick    = sample_en && (time_left == ONE);
        state_change = 1'b0;
        if (abort) begin
            state_change = (st != ST_IDLE);
        end else begin
            case (st)
                ST_IDLE, ST_GAME_OVER: state_change = start;
                ST_COUNTDOWN, ST_PLAY: state_change = last_tick;
                default:               state_change = 1'b0;
            endcase
        end
    end

    // The divider restarts on every transition so each state's first tick is a full period away
    sample_tick_gen #(
        .DIV(SAMPLE_DIV)
    ) u_tick (
        .clock  (clock),
        .reset  (reset),
        .enable (st != ST_IDLE),
        .clear  (state_change),
        .tick   (sample_en)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st         <= ST_IDLE;
            score      <= '0;
            high_score <= '0;
            time_left  <= '0;
            new_high   <= 1'b0;
        end else if (abort) begin
            st        <= ST_IDLE;
            score     <= '0;
            time_left <= '0;
            new_high  <= 1'b0;
        end else begin
            case (st)
                ST_IDLE, ST_GAME_OVER: begin
                    if (start) begin
                        st        <= ST_COUNTDOWN;
                        score     <= '0;
                        time_left <= CD_LOAD;
                        new_high  <= 1'b0;
                    end
                end
                ST_COUNTDOWN: begin
                    if (last_tick) begin
                        st        <= ST_PLAY;
                        time_left <= RT_LOAD;
                    end else if (sample_en) begin
                        time_left <= time_left - ONE;
                    end
                end
                ST_PLAY: begin
                    if (sample_en) begin
                        score <= score_inc;
                        // The final tick's hit counts towards the high-score compare
                        if (time_left == ONE) begin
                            st        <= ST_GAME_OVER;
                            time_left <= '0;
                            if (score_inc > high_score) begin
                                high_score <= score_inc;
                                new_high   <= 1'b1;
                            end
                        end else begin
                            time_left <= time_left - ONE;
                        end
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_round_controller.sv
// Bench for game_round_controller: directed table, hand sequences and random
// stimulus checked against a cycle-level behavioural model of the round rules.
module tb_game_round_controller;

    localparam int DIV = 4;
    localparam int CD  = 2;
    localparam int RT  = 5;
    localparam int SW  = 3;
    localparam int TW  = 8;
    localparam int SMAX = (1 << SW) - 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic in_hit = 1'b0;
    logic          sample_en;
    logic [1:0]    state;
    logic [SW-1:0] score, high_score;
    logic [TW-1:0] time_left;
    logic          new_high;

    logic          s_start = 1'b0;
    logic          s_in = 1'b0;
    logic          s_abort = 1'b0;
    logic          s_sample_en;
    logic [1:0]    s_state;
    logic [SW-1:0] s_score, s_high;
    logic [TW-1:0] s_time;
    logic          s_new;

    int vectors = 0;
    int miscompares = 0;

    int m_state, m_age, m_score, m_hi, m_time, m_new;

    typedef struct {
        int start, abort, hit, cycles;
        int st, sc, hi, tl, nh, se;
    } vec_t;
    vec_t tbl[$];

    always #5 clock = ~clock;

    game_round_controller #(
        .SAMPLE_DIV(DIV), .COUNTDOWN_TICKS(CD), .ROUND_TICKS(RT), .SCORE_W(SW), .TIME_W(TW)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .in(in_hit),
        .sample_en(sample_en), .state(state), .score(score), .high_score(high_score),
        .time_left(time_left), .new_high(new_high)
    );

    game_round_controller #(
        .SAMPLE_DIV(DIV), .COUNTDOWN_TICKS(CD), .ROUND_TICKS(10), .SCORE_W(SW), .TIME_W(TW)
    ) dut_sat (
        .clock(clock), .reset(reset), .start(s_start), .abort(s_abort), .in(s_in),
        .sample_en(s_sample_en), .state(s_state), .score(s_score), .high_score(s_high),
        .time_left(s_time), .new_high(s_new)
    );

    task automatic model_reset();
        m_state = 0; m_age = 0; m_score = 0; m_hi = 0; m_time = 0; m_new = 0;
    endtask

    function automatic int model_sample();
        return (m_state != 0 && (m_age % DIV) == DIV - 1) ? 1 : 0;
    endfunction

    // One clock edge of the round rules: abort > start > tick, ticks only act in COUNTDOWN/PLAY
    task automatic model_step(input int st, input int ab, input int hit);
        int tick;
        int nxt;
        tick = model_sample();
        nxt = m_state;
        if (ab != 0) begin
            nxt = 0; m_score = 0; m_time = 0; m_new = 0;
        end else if ((m_state == 0 || m_state == 3) && st != 0) begin
            nxt = 1; m_score = 0; m_time = CD; m_new = 0;
        end else if (tick != 0 && m_state == 1) begin
            if (m_time == 1) begin nxt = 2; m_time = RT; end
            else m_time = m_time - 1;
        end else if (tick != 0 && m_state == 2) begin
            m_score = (m_score + hit > SMAX) ? SMAX : m_score + hit;
            if (m_time == 1) begin
                nxt = 3; m_time = 0;
                if (m_score > m_hi) begin m_hi = m_score; m_new = 1; end
            end else begin
                m_time = m_time - 1;
            end
        end
        if (nxt != m_state || nxt == 0) m_age = 0;
        else m_age = m_age + 1;
        m_state = nxt;
    endtask

    task automatic check(input string name, input logic [1:0] e_st, input logic [SW-1:0] e_sc,
                         input logic [SW-1:0] e_hi, input logic [TW-1:0] e_tl,
                         input logic e_nh, input logic e_se);
        vectors++;
        if (state !== e_st || score !== e_sc || high_score !== e_hi || time_left !== e_tl ||
            new_high !== e_nh || sample_en !== e_se) begin
            miscompares++;
            $display("FAIL %s @%0t: got st=%0d sc=%0d hi=%0d tl=%0d nh=%0b se=%0b, expected st=%0d sc=%0d hi=%0d tl=%0d nh=%0b se=%0b",
                     name, $time, state, score, high_score, time_left, new_high, sample_en,
                     e_st, e_sc, e_hi, e_tl, e_nh, e_se);
        end
    endtask

    task automatic check_model(input string name);
        check(name, 2'(m_state), SW'(m_score), SW'(m_hi), TW'(m_time), m_new != 0, model_sample() != 0);
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Drive inputs just after an edge, take the next edge, then compare against the model
    task automatic step(input int st, input int ab, input int hit);
        start = (st != 0);
        abort = (ab != 0);
        in_hit = (hit != 0);
        @(posedge clock);
        #1;
        model_step(st, ab, hit);
        check_model("model");
    endtask

    task automatic run(input int n, input int st, input int ab, input int hit);
        for (int i = 0; i < n; i++) step(st, ab, hit);
    endtask

    task automatic sync_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int mono_bad;
        int cnt;

        //             start abort hit cyc   st sc hi tl nh se
        tbl.push_back(vec_t'{1, 0, 0, 1,     1, 0, 0, 2, 0, 0});
        tbl.push_back(vec_t'{0, 0, 0, 3,     1, 0, 0, 2, 0, 1});
        tbl.push_back(vec_t'{0, 0, 0, 1,     1, 0, 0, 1, 0, 0});
        tbl.push_back(vec_t'{0, 0, 0, 4,     2, 0, 0, 5, 0, 0});
        tbl.push_back(vec_t'{0, 0, 1, 4,     2, 1, 0, 4, 0, 0});
        tbl.push_back(vec_t'{0, 0, 1, 16,    3, 5, 5, 0, 1, 0});
        tbl.push_back(vec_t'{0, 0, 0, 3,     3, 5, 5, 0, 1, 1});
        tbl.push_back(vec_t'{1, 0, 0, 1,     1, 0, 5, 2, 0, 0});
        tbl.push_back(vec_t'{0, 0, 0, 8,     2, 0, 5, 5, 0, 0});
        tbl.push_back(vec_t'{0, 0, 1, 12,    2, 3, 5, 2, 0, 0});
        tbl.push_back(vec_t'{0, 0, 0, 8,     3, 3, 5, 0, 0, 0});
        tbl.push_back(vec_t'{1, 0, 0, 1,     1, 0, 5, 2, 0, 0});
        tbl.push_back(vec_t'{0, 0, 0, 8,     2, 0, 5, 5, 0, 0});
        tbl.push_back(vec_t'{0, 0, 1, 20,    3, 5, 5, 0, 0, 0});
        tbl.push_back(vec_t'{1, 0, 0, 1,     1, 0, 5, 2, 0, 0});
        tbl.push_back(vec_t'{0, 0, 0, 8,     2, 0, 5, 5, 0, 0});
        tbl.push_back(vec_t'{0, 0, 1, 8,     2, 2, 5, 3, 0, 0});
        tbl.push_back(vec_t'{0, 1, 0, 1,     0, 0, 5, 0, 0, 0});
        tbl.push_back(vec_t'{0, 0, 0, 5,     0, 0, 5, 0, 0, 0});
        tbl.push_back(vec_t'{1, 0, 0, 1,     1, 0, 5, 2, 0, 0});
        tbl.push_back(vec_t'{1, 0, 0, 8,     2, 0, 5, 5, 0, 0});
        tbl.push_back(vec_t'{1, 0, 1, 20,    3, 5, 5, 0, 0, 0});
        tbl.push_back(vec_t'{1, 0, 0, 1,     1, 0, 5, 2, 0, 0});
        tbl.push_back(vec_t'{1, 1, 0, 1,     0, 0, 5, 0, 0, 0});

        // Reset state
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check("reset", 2'd0, '0, '0, '0, 1'b0, 1'b0);
        reset = 1'b0;

        // Directed table
        foreach (tbl[i]) begin
            run(tbl[i].cycles, tbl[i].start, tbl[i].abort, tbl[i].hit);
            check($sformatf("table[%0d]", i), 2'(tbl[i].st), SW'(tbl[i].sc), SW'(tbl[i].hi),
                  TW'(tbl[i].tl), tbl[i].nh != 0, tbl[i].se != 0);
        end

        // Asynchronous reset mid-PLAY with score 3 and high score 2
        sync_reset();
        step(1, 0, 0); run(8, 0, 0, 0); run(8, 0, 0, 1); run(12, 0, 0, 0);
        check("hi_two", 2'd3, SW'(2), SW'(2), '0, 1'b1, 1'b0);
        step(1, 0, 0); run(8, 0, 0, 0); run(12, 0, 0, 1);
        check("pre_reset_play", 2'd2, SW'(3), SW'(2), TW'(2), 1'b0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset", 2'd0, '0, '0, '0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();

        // Saturation on a 10-tick round with a 3-bit score
        s_start = 1'b1;
        step(0, 0, 0);
        s_start = 1'b0;
        s_in = 1'b1;
        prev = 0;
        mono_bad = 0;
        cnt = 0;
        while (s_state != 2'd3 && cnt < 100) begin
            step(0, 0, 0);
            if (int'(s_score) < prev) mono_bad = 1;
            prev = int'(s_score);
            cnt++;
        end
        check_val("sat_reached_game_over", int'(s_state), 3);
        check_val("sat_score", int'(s_score), SMAX);
        check_val("sat_high", int'(s_high), SMAX);
        check_val("sat_no_wrap", mono_bad, 0);
        s_in = 1'b0;

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 19) == 0) ? 1 : 0,
                 ($urandom_range(0, 79) == 0) ? 1 : 0,
                 int'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
